mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-port unified memory shared by the IF stage (instruction fetch) and the MEM stage (load/store). It grants one access at a time with data priority and runs a fixed-latency access counter. It latches each result into a per-requester hold register and drives a global `stall` that freezes PC, IF/ID and the later pipeline registers until every pending access of the current cycle has completed. It sits between the pipeline and the memory model, alongside the hazard detection unit, whose `PCWrite`/`IIWrite` are ANDed with `~stall` at top level.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data requests win arbitration. Each access runs a fixed-latency counter.
// Results land in per-requester hold registers. A global stall holds the
// pipeline until every pending request of the current cycle has completed.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              issue_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;

  logic i_pend, d_pend;
  logic cmpl, i_cmpl, d_cmpl;
  logic grant_i, grant_d;

  // A request is pending until its access has completed in this stall window.
  assign i_pend = if_req & ~if_done_q;
  assign d_pend = d_req & ~d_done_q;
  assign stall  = i_pend | d_pend;

  // The cycle where the counter reaches zero is the completion cycle.
  assign cmpl   = (state_q != IDLE) && (cnt_q == 4'd0);
  assign i_cmpl = cmpl && (state_q == BUSY_I);
  assign d_cmpl = cmpl && (state_q == BUSY_D);

  // Grant selection. Data has priority from IDLE. A completing requester
  // only hands over to the other side, so it is never re-granted at once.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = d_pend;
        grant_i = ~d_pend & i_pend;
      end
      BUSY_I:  grant_d = cmpl & d_pend;
      BUSY_D:  grant_i = cmpl & i_pend;
      default: ;
    endcase
  end

  // Access sequencer: latch the request on a grant, issue one strobe, count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      issue_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      issue_q <= 1'b0;
      if (grant_d) begin
        state_q <= BUSY_D;
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
        cnt_q   <= LAT;
        issue_q <= 1'b1;
      end else if (grant_i) begin
        state_q <= BUSY_I;
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        cnt_q   <= LAT;
        issue_q <= 1'b1;
      end else if (cmpl) begin
        state_q <= IDLE;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Result capture. A withdrawn request discards its data; stores leave d_rdata alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (i_cmpl && if_req) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_cmpl && d_req && !we_q) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Done flags block re-issue of a held request until the stall clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      if (!if_req || !stall) begin
        if_done_q <= 1'b0;
      end else if (i_cmpl) begin
        if_done_q <= 1'b1;
      end
      if (!d_req || !stall) begin
        d_done_q <= 1'b0;
      end else if (d_cmpl) begin
        d_done_q <= 1'b1;
      end
    end
  end

  assign mem_en    = issue_q;
  assign mem_we    = issue_q & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: u0 runs with MEM_LAT=2, u1 with MEM_LAT=1.
// Both instances share the same inputs. Each test checks one instance.
module tb_mem_port_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0;
  logic        mem_en0, mem_we0, stall0;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        mem_en1, mem_we1, stall1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .ADDR_W(32), .DATA_W(32)) u0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata), .stall(stall0)
  );

  mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(32)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .stall(stall1)
  );

  // Advance to just after the next rising edge; inputs for that cycle are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_rdata = JUNK;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = JUNK;
    #3;
    checks++;
    if ({mem_en0, mem_we0, stall0} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl en/we/stall=%b want 000", {mem_en0, mem_we0, stall0});
    end
    checks++;
    if ({if_rdata0, d_rdata0, mem_addr0, mem_wdata0} !== 128'd0) begin
      errors++; $display("FAIL reset_regs if=%h d=%h a=%h w=%h want 0", if_rdata0, d_rdata0, mem_addr0, mem_wdata0);
    end
    if_req = 1'b1;
    #1;
    checks++;
    if (stall0 !== 1'b1) begin
      errors++; $display("FAIL reset_stall_follows_req stall=%b want 1", stall0);
    end
    if_req = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    #2;
    checks++;
    if (mem_en0 !== 1'b0) begin
      errors++; $display("FAIL reset_idle mem_en=%b want 0", mem_en0);
    end
    idle(3);
  endtask

  task automatic test_lone_fetch();
    logic [4:0] en_exp    = 5'b00010;
    logic [4:0] stall_exp = 5'b01111;
    for (int c = 0; c <= 4; c++) begin
      cyc();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h00400000; end
      mem_rdata = (c == 3) ? 32'h8C080004 : JUNK;
      #2;
      checks++;
      if (mem_en0 !== en_exp[c] || stall0 !== stall_exp[c]) begin
        errors++; $display("FAIL lone_fetch c%0d en=%b stall=%b want en=%b stall=%b", c, mem_en0, stall0, en_exp[c], stall_exp[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr0 !== 32'h00400000 || mem_we0 !== 1'b0) begin
          errors++; $display("FAIL lone_fetch_addr addr=%h we=%b want 00400000 0", mem_addr0, mem_we0);
        end
      end
      if (c == 4) begin
        checks++;
        if (if_rdata0 !== 32'h8C080004) begin
          errors++; $display("FAIL lone_fetch_rdata if_rdata=%h want 8c080004", if_rdata0);
        end
      end
    end
    idle(5);
  endtask

  task automatic test_load_fetch();
    logic [7:0] en_exp    = 8'b0001_0010;
    logic [7:0] stall_exp = 8'b0111_1111;
    for (int c = 0; c <= 7; c++) begin
      cyc();
      if (c == 0) begin
        if_req = 1'b1; if_addr = 32'h00400004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010000;
      end
      mem_rdata = (c == 3) ? 32'h11112222 : (c == 6) ? 32'h33334444 : JUNK;
      #2;
      checks++;
      if (mem_en0 !== en_exp[c] || stall0 !== stall_exp[c]) begin
        errors++; $display("FAIL load_fetch c%0d en=%b stall=%b want en=%b stall=%b", c, mem_en0, stall0, en_exp[c], stall_exp[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr0 !== 32'h10010000 || mem_we0 !== 1'b0) begin
          errors++; $display("FAIL load_fetch_daddr addr=%h we=%b want 10010000 0", mem_addr0, mem_we0);
        end
      end
      if (c == 4) begin
        checks++;
        if (mem_addr0 !== 32'h00400004 || d_rdata0 !== 32'h11112222) begin
          errors++; $display("FAIL load_fetch_iaddr addr=%h d_rdata=%h want 00400004 11112222", mem_addr0, d_rdata0);
        end
      end
      if (c == 7) begin
        checks++;
        if (if_rdata0 !== 32'h33334444 || d_rdata0 !== 32'h11112222) begin
          errors++; $display("FAIL load_fetch_rdata if=%h d=%h want 33334444 11112222", if_rdata0, d_rdata0);
        end
      end
    end
    idle(5);
  endtask

  task automatic test_store();
    logic [4:0] en_exp    = 5'b00010;
    logic [4:0] stall_exp = 5'b01111;
    for (int c = 0; c <= 4; c++) begin
      cyc();
      if (c == 0) begin
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10010004; d_wdata = 32'hDEADBEEF;
      end
      mem_rdata = (c == 3) ? 32'h55555555 : JUNK;
      #2;
      checks++;
      if (mem_en0 !== en_exp[c] || mem_we0 !== en_exp[c] || stall0 !== stall_exp[c]) begin
        errors++; $display("FAIL store c%0d en=%b we=%b stall=%b want en=we=%b stall=%b", c, mem_en0, mem_we0, stall0, en_exp[c], stall_exp[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_wdata0 !== 32'hDEADBEEF || mem_addr0 !== 32'h10010004) begin
          errors++; $display("FAIL store_latch wdata=%h addr=%h want deadbeef 10010004", mem_wdata0, mem_addr0);
        end
      end
      if (c == 4) begin
        checks++;
        if (d_rdata0 !== 32'h11112222) begin
          errors++; $display("FAIL store_rdata_kept d_rdata=%h want 11112222", d_rdata0);
        end
      end
    end
    idle(5);
  endtask

  task automatic test_withdraw();
    logic [8:0] en_exp    = 9'b0_0010_0010;
    logic [8:0] stall_exp = 9'b0_1111_0011;
    for (int c = 0; c <= 8; c++) begin
      cyc();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h00400008; end
      if (c == 2) if_req = 1'b0;
      if (c == 4) begin if_req = 1'b1; if_addr = 32'h0040000C; end
      mem_rdata = (c == 3) ? 32'h77778888 : (c == 7) ? 32'h9999AAAA : JUNK;
      #2;
      checks++;
      if (mem_en0 !== en_exp[c] || stall0 !== stall_exp[c]) begin
        errors++; $display("FAIL withdraw c%0d en=%b stall=%b want en=%b stall=%b", c, mem_en0, stall0, en_exp[c], stall_exp[c]);
      end
      if (c == 4) begin
        checks++;
        if (if_rdata0 !== 32'h33334444) begin
          errors++; $display("FAIL withdraw_discard if_rdata=%h want 33334444", if_rdata0);
        end
      end
      if (c == 5) begin
        checks++;
        if (mem_addr0 !== 32'h0040000C) begin
          errors++; $display("FAIL withdraw_reissue addr=%h want 0040000c", mem_addr0);
        end
      end
      if (c == 8) begin
        checks++;
        if (if_rdata0 !== 32'h9999AAAA) begin
          errors++; $display("FAIL withdraw_rdata if_rdata=%h want 9999aaaa", if_rdata0);
        end
      end
    end
    idle(5);
  endtask

  task automatic test_reset_mid();
    logic [7:0] en_exp    = 8'b0001_0010;
    logic [7:0] stall_exp = 8'b0111_1111;
    for (int c = 0; c <= 7; c++) begin
      cyc();
      if (c == 0) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010008; end
      if (c == 2) rst_n = 1'b0;
      if (c == 3) rst_n = 1'b1;
      mem_rdata = (c == 6) ? 32'hCAFEF00D : JUNK;
      #2;
      checks++;
      if (mem_en0 !== en_exp[c] || stall0 !== stall_exp[c]) begin
        errors++; $display("FAIL reset_mid c%0d en=%b stall=%b want en=%b stall=%b", c, mem_en0, stall0, en_exp[c], stall_exp[c]);
      end
      if (c == 2) begin
        checks++;
        if ({if_rdata0, d_rdata0, mem_addr0} !== 96'd0) begin
          errors++; $display("FAIL reset_mid_clear if=%h d=%h addr=%h want 0", if_rdata0, d_rdata0, mem_addr0);
        end
      end
      if (c == 4) begin
        checks++;
        if (mem_addr0 !== 32'h10010008) begin
          errors++; $display("FAIL reset_mid_regrant addr=%h want 10010008", mem_addr0);
        end
      end
      if (c == 7) begin
        checks++;
        if (d_rdata0 !== 32'hCAFEF00D) begin
          errors++; $display("FAIL reset_mid_rdata d_rdata=%h want cafef00d", d_rdata0);
        end
      end
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    logic [5:0] en_exp    = 6'b00_1010;
    logic [5:0] stall_exp = 6'b01_1111;
    for (int c = 0; c <= 5; c++) begin
      cyc();
      if (c == 0) begin
        if_req = 1'b1; if_addr = 32'h00400010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010010;
      end
      mem_rdata = (c == 2) ? 32'h0A0B0C0D : (c == 4) ? 32'h01020304 : JUNK;
      #2;
      checks++;
      if (mem_en1 !== en_exp[c] || stall1 !== stall_exp[c]) begin
        errors++; $display("FAIL b2b c%0d en=%b stall=%b want en=%b stall=%b", c, mem_en1, stall1, en_exp[c], stall_exp[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr1 !== 32'h10010010) begin
          errors++; $display("FAIL b2b_daddr addr=%h want 10010010", mem_addr1);
        end
      end
      if (c == 3) begin
        checks++;
        if (mem_addr1 !== 32'h00400010 || d_rdata1 !== 32'h0A0B0C0D) begin
          errors++; $display("FAIL b2b_iaddr addr=%h d_rdata=%h want 00400010 0a0b0c0d", mem_addr1, d_rdata1);
        end
      end
      if (c == 5) begin
        checks++;
        if (if_rdata1 !== 32'h01020304) begin
          errors++; $display("FAIL b2b_rdata if_rdata=%h want 01020304", if_rdata1);
        end
      end
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_load_fetch();
    test_store();
    test_withdraw();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
